uart_receiver: RTL and testbench

Serial-to-parallel UART receiver for 8N1 frames (one start bit, 8 data bits LSB first, one stop bit, no parity). It sits directly downstream of the UART transmit stage and consumes its tx line. It samples each bit at mid-period using a programmable clocks-per-bit divider, and presents each received byte on a valid/ready handshake. With CLKS_PER_BIT = 1 it accepts the transmit stage's one-bit-per-clock output directly.

---
 rtl/uart_receiver_if.sv | 12 +
 rtl/uart_receiver.sv | 103 ++++++++++
 tb/tb_uart_receiver.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_receiver_if.sv
// Byte-side handshake of the UART receiver: received byte with valid/ready,
// plus the one-cycle frame error and overrun event pulses.
interface uart_receiver_if;
  logic [7:0] data;
  logic       valid;
  logic       ready;
  logic       frame_err;
  logic       overrun;

  modport master (output data, valid, frame_err, overrun, input ready);
  modport slave  (input data, valid, frame_err, overrun, output ready);
endinterface

// File: rtl/uart_receiver.sv
// 8N1 UART receiver: mid-bit sampling with a programmable clocks-per-bit
// divider, byte presented on a valid/ready handshake with error pulses.
module uart_receiver #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             rx,
  uart_receiver_if.master  bus
);

  localparam logic [15:0] LAST = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0] HALF = 16'((CLKS_PER_BIT - 1) / 2);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} state_t;

  state_t      state;
  logic        sync_p0;
  logic        rxs;
  logic [15:0] cnt;
  logic [3:0]  bit_idx;
  logic [7:0]  shift;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      sync_p0       <= 1'b1;
      rxs           <= 1'b1;
      cnt           <= 16'd0;
      bit_idx       <= 4'd0;
      shift         <= 8'h00;
      bus.data      <= 8'h00;
      bus.valid     <= 1'b0;
      bus.frame_err <= 1'b0;
      bus.overrun   <= 1'b0;
    end else begin
      sync_p0       <= rx;
      rxs           <= sync_p0;
      bus.frame_err <= 1'b0;
      bus.overrun   <= 1'b0;
      if (bus.valid && bus.ready) bus.valid <= 1'b0;

      case (state)
        IDLE: begin
          // With a zero half-period the start sample is this very cycle.
          if (!rxs) begin
            bit_idx <= 4'd0;
            if (HALF == 16'd0) begin
              cnt   <= 16'd0;
              state <= DATA;
            end else begin
              cnt   <= 16'd1;
              state <= START;
            end
          end
        end
        START: begin
          if (cnt == HALF) begin
            cnt   <= 16'd0;
            state <= rxs ? IDLE : DATA;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        DATA: begin
          if (cnt == LAST) begin
            cnt   <= 16'd0;
            shift <= {rxs, shift[7:1]};
            if (bit_idx == 4'd7) state <= STOP;
            else bit_idx <= bit_idx + 4'd1;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        STOP: begin
          if (cnt == LAST) begin
            cnt <= 16'd0;
            if (rxs) begin
              state <= IDLE;
              // A byte being consumed this cycle frees the holding register.
              if (!bus.valid || bus.ready) begin
                bus.data  <= shift;
                bus.valid <= 1'b1;
              end else begin
                bus.overrun <= 1'b1;
              end
            end else begin
              bus.frame_err <= 1'b1;
              state         <= WAIT_HIGH;
            end
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        WAIT_HIGH: begin
          if (rxs) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_receiver.sv
// Bench for uart_receiver: three instances (1, 4 and 16 clocks per bit)
// driven serially and compared against a frame-level timing model.
`timescale 1ns/1ps
module tb_uart_receiver;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] rx_line = 3'b111;
  logic [2:0] ready_line = 3'b111;
  logic [2:0] valid_w;
  logic [2:0] ferr_w;
  logic [2:0] ovr_w;
  logic [7:0] data_w [3];

  int cyc = 0;
  int errors = 0;
  int checks = 0;

  int         vcyc [3][$];
  logic [7:0] vdat [3][$];
  int         ferr_cyc [3][$];
  int         ovr_cyc [3][$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int CPB = (g == 0) ? 1 : (g == 1) ? 4 : 16;
    uart_receiver_if bus ();
    assign bus.ready = ready_line[g];
    uart_receiver #(.CLKS_PER_BIT(CPB)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .rx    (rx_line[g]),
      .bus   (bus.master)
    );
    assign valid_w[g] = bus.valid;
    assign data_w[g]  = bus.data;
    assign ferr_w[g]  = bus.frame_err;
    assign ovr_w[g]   = bus.overrun;
  end

  // Event log: transfers, frame errors and overruns with their cycle numbers.
  always @(negedge clk) begin
    if (rst_n) begin
      for (int d = 0; d < 3; d++) begin
        if (valid_w[d] && ready_line[d]) begin
          vcyc[d].push_back(cyc);
          vdat[d].push_back(data_w[d]);
        end
        if (ferr_w[d]) ferr_cyc[d].push_back(cyc);
        if (ovr_w[d])  ovr_cyc[d].push_back(cyc);
      end
    end
  end

  function automatic int cpb_of(input int d);
    return (d == 0) ? 1 : (d == 1) ? 4 : 16;
  endfunction

  // Cycle in which a frame whose start edge was driven after edge p completes.
  function automatic int done_cycle(input int d, input int p);
    int cpb;
    cpb = cpb_of(d);
    return p + 2 + (cpb - 1) / 2 + 9 * cpb + 1;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    for (int d = 0; d < 3; d++) begin
      vcyc[d].delete(); vdat[d].delete();
      ferr_cyc[d].delete(); ovr_cyc[d].delete();
    end
  endtask

  task automatic send_frame(input int d, input logic [7:0] b, input logic stop, output int p);
    int cpb;
    cpb = cpb_of(d);
    p = cyc;
    rx_line[d] = 1'b0;
    tick(cpb);
    for (int i = 0; i < 8; i++) begin
      rx_line[d] = b[i];
      tick(cpb);
    end
    rx_line[d] = stop;
    tick(cpb);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick(4);
    for (int d = 0; d < 3; d++) begin
      checks++; if (valid_w[d] !== 1'b0) begin errors++; $display("FAIL reset_valid[%0d]: got %b expected 0", d, valid_w[d]); end
      checks++; if (data_w[d] !== 8'h00) begin errors++; $display("FAIL reset_data[%0d]: got %h expected 00", d, data_w[d]); end
      checks++; if (ferr_w[d] !== 1'b0) begin errors++; $display("FAIL reset_ferr[%0d]: got %b expected 0", d, ferr_w[d]); end
      checks++; if (ovr_w[d] !== 1'b0) begin errors++; $display("FAIL reset_ovr[%0d]: got %b expected 0", d, ovr_w[d]); end
    end
    rst_n = 1'b1;
    tick(4);
  endtask

  task automatic test_cpb1_latency();
    int p;
    clear_log();
    send_frame(0, 8'hA5, 1'b1, p);
    tick(6);
    checks++; if (vcyc[0].size() !== 1) begin errors++; $display("FAIL cpb1_count: got %0d expected 1", vcyc[0].size()); end
    if (vcyc[0].size() > 0) begin
      checks++; if (vcyc[0][0] !== p + 12) begin errors++; $display("FAIL cpb1_latency: got %0d expected %0d", vcyc[0][0] - p, 12); end
      checks++; if (vdat[0][0] !== 8'hA5) begin errors++; $display("FAIL cpb1_data: got %h expected a5", vdat[0][0]); end
    end
    checks++; if (ferr_cyc[0].size() + ovr_cyc[0].size() !== 0) begin errors++; $display("FAIL cpb1_err_pulses: got %0d expected 0", ferr_cyc[0].size() + ovr_cyc[0].size()); end
  endtask

  task automatic test_back_to_back();
    int p1, p2;
    clear_log();
    send_frame(2, 8'h3C, 1'b1, p1);
    send_frame(2, 8'hC3, 1'b1, p2);
    tick(20);
    checks++; if (vcyc[2].size() !== 2) begin errors++; $display("FAIL b2b_count: got %0d expected 2", vcyc[2].size()); end
    if (vcyc[2].size() == 2) begin
      checks++; if (vdat[2][0] !== 8'h3C) begin errors++; $display("FAIL b2b_data0: got %h expected 3c", vdat[2][0]); end
      checks++; if (vdat[2][1] !== 8'hC3) begin errors++; $display("FAIL b2b_data1: got %h expected c3", vdat[2][1]); end
      checks++; if (vcyc[2][1] - vcyc[2][0] !== 160) begin errors++; $display("FAIL b2b_spacing: got %0d expected 160", vcyc[2][1] - vcyc[2][0]); end
      checks++; if (vcyc[2][0] !== p1 + 154) begin errors++; $display("FAIL b2b_latency: got %0d expected 154", vcyc[2][0] - p1); end
    end
  endtask

  task automatic test_glitch();
    int p;
    clear_log();
    rx_line[2] = 1'b0;
    tick(3);
    rx_line[2] = 1'b1;
    tick(40);
    checks++; if (vcyc[2].size() !== 0) begin errors++; $display("FAIL glitch_valid: got %0d expected 0", vcyc[2].size()); end
    checks++; if (ferr_cyc[2].size() !== 0) begin errors++; $display("FAIL glitch_ferr: got %0d expected 0", ferr_cyc[2].size()); end
    send_frame(2, 8'h5A, 1'b1, p);
    tick(20);
    checks++; if (vcyc[2].size() !== 1) begin errors++; $display("FAIL glitch_next_count: got %0d expected 1", vcyc[2].size()); end
    if (vcyc[2].size() > 0) begin
      checks++; if (vdat[2][0] !== 8'h5A) begin errors++; $display("FAIL glitch_next_data: got %h expected 5a", vdat[2][0]); end
    end
  endtask

  task automatic test_break();
    int p1, p2;
    clear_log();
    send_frame(1, 8'h55, 1'b0, p1);
    tick(50);
    rx_line[1] = 1'b1;
    tick(8);
    send_frame(1, 8'h12, 1'b1, p2);
    tick(10);
    checks++; if (ferr_cyc[1].size() !== 1) begin errors++; $display("FAIL break_ferr_count: got %0d expected 1", ferr_cyc[1].size()); end
    if (ferr_cyc[1].size() > 0) begin
      checks++; if (ferr_cyc[1][0] !== p1 + 40) begin errors++; $display("FAIL break_ferr_time: got %0d expected 40", ferr_cyc[1][0] - p1); end
    end
    checks++; if (vcyc[1].size() !== 1) begin errors++; $display("FAIL break_valid_count: got %0d expected 1", vcyc[1].size()); end
    if (vcyc[1].size() > 0) begin
      checks++; if (vdat[1][0] !== 8'h12) begin errors++; $display("FAIL break_data: got %h expected 12", vdat[1][0]); end
      checks++; if (vcyc[1][0] !== p2 + 40) begin errors++; $display("FAIL break_latency: got %0d expected 40", vcyc[1][0] - p2); end
    end
    checks++; if (ovr_cyc[1].size() !== 0) begin errors++; $display("FAIL break_ovr: got %0d expected 0", ovr_cyc[1].size()); end
  endtask

  task automatic test_overrun();
    int p1, p2;
    clear_log();
    ready_line[1] = 1'b0;
    send_frame(1, 8'h11, 1'b1, p1);
    send_frame(1, 8'h22, 1'b1, p2);
    tick(10);
    checks++; if (valid_w[1] !== 1'b1) begin errors++; $display("FAIL ovr_valid_held: got %b expected 1", valid_w[1]); end
    checks++; if (data_w[1] !== 8'h11) begin errors++; $display("FAIL ovr_data_held: got %h expected 11", data_w[1]); end
    checks++; if (ovr_cyc[1].size() !== 1) begin errors++; $display("FAIL ovr_count: got %0d expected 1", ovr_cyc[1].size()); end
    if (ovr_cyc[1].size() > 0) begin
      checks++; if (ovr_cyc[1][0] !== done_cycle(1, p2)) begin errors++; $display("FAIL ovr_time: got %0d expected %0d", ovr_cyc[1][0], done_cycle(1, p2)); end
    end
    ready_line[1] = 1'b1;
    tick(1);
    ready_line[1] = 1'b0;
    tick(20);
    checks++; if (valid_w[1] !== 1'b0) begin errors++; $display("FAIL ovr_valid_drop: got %b expected 0", valid_w[1]); end
    checks++; if (vcyc[1].size() !== 1) begin errors++; $display("FAIL ovr_transfers: got %0d expected 1", vcyc[1].size()); end
    if (vcyc[1].size() > 0) begin
      checks++; if (vdat[1][0] !== 8'h11) begin errors++; $display("FAIL ovr_transfer_data: got %h expected 11", vdat[1][0]); end
    end
    checks++; if (ferr_cyc[1].size() !== 0) begin errors++; $display("FAIL ovr_ferr: got %0d expected 0", ferr_cyc[1].size()); end
    ready_line[1] = 1'b1;
  endtask

  task automatic test_reset_midframe();
    int p;
    clear_log();
    rx_line[2] = 1'b0;
    tick(16);
    rx_line[2] = 1'b1;
    tick(4 * 16 + 8);
    rst_n = 1'b0;
    tick(3);
    checks++; if (valid_w[2] !== 1'b0) begin errors++; $display("FAIL rstmid_valid: got %b expected 0", valid_w[2]); end
    checks++; if (data_w[2] !== 8'h00) begin errors++; $display("FAIL rstmid_data: got %h expected 00", data_w[2]); end
    checks++; if ({ferr_w[2], ovr_w[2]} !== 2'b00) begin errors++; $display("FAIL rstmid_pulses: got %b expected 00", {ferr_w[2], ovr_w[2]}); end
    rst_n = 1'b1;
    tick(100);
    checks++; if (vcyc[2].size() + ferr_cyc[2].size() !== 0) begin errors++; $display("FAIL rstmid_aborted: got %0d expected 0", vcyc[2].size() + ferr_cyc[2].size()); end
    send_frame(2, 8'h81, 1'b1, p);
    tick(20);
    checks++; if (vcyc[2].size() !== 1) begin errors++; $display("FAIL rstmid_next_count: got %0d expected 1", vcyc[2].size()); end
    if (vcyc[2].size() > 0) begin
      checks++; if (vdat[2][0] !== 8'h81) begin errors++; $display("FAIL rstmid_next_data: got %h expected 81", vdat[2][0]); end
    end
  endtask

  task automatic test_random();
    int         exp_cyc [3][$];
    logic [7:0] exp_dat [3][$];
    int         exp_ferr [3][$];
    int         p, d;
    logic [7:0] b;
    logic       stop;
    clear_log();
    for (int n = 0; n < 14; n++) begin
      d    = $urandom_range(0, 2);
      b    = 8'($urandom);
      stop = ($urandom_range(0, 4) != 0);
      send_frame(d, b, stop, p);
      if (stop) begin
        exp_cyc[d].push_back(done_cycle(d, p));
        exp_dat[d].push_back(b);
        tick($urandom_range(0, 3));
      end else begin
        exp_ferr[d].push_back(done_cycle(d, p));
        rx_line[d] = 1'b1;
        tick(cpb_of(d) + 3);
      end
    end
    tick(40);
    for (int k = 0; k < 3; k++) begin
      checks++; if (vcyc[k].size() !== exp_cyc[k].size()) begin errors++; $display("FAIL rand_count[%0d]: got %0d expected %0d", k, vcyc[k].size(), exp_cyc[k].size()); end
      checks++; if (ferr_cyc[k].size() !== exp_ferr[k].size()) begin errors++; $display("FAIL rand_ferr_count[%0d]: got %0d expected %0d", k, ferr_cyc[k].size(), exp_ferr[k].size()); end
      for (int i = 0; i < vcyc[k].size() && i < exp_cyc[k].size(); i++) begin
        checks++; if (vdat[k][i] !== exp_dat[k][i]) begin errors++; $display("FAIL rand_data[%0d][%0d]: got %h expected %h", k, i, vdat[k][i], exp_dat[k][i]); end
        checks++; if (vcyc[k][i] !== exp_cyc[k][i]) begin errors++; $display("FAIL rand_time[%0d][%0d]: got %0d expected %0d", k, i, vcyc[k][i], exp_cyc[k][i]); end
      end
      for (int i = 0; i < ferr_cyc[k].size() && i < exp_ferr[k].size(); i++) begin
        checks++; if (ferr_cyc[k][i] !== exp_ferr[k][i]) begin errors++; $display("FAIL rand_ferr_time[%0d][%0d]: got %0d expected %0d", k, i, ferr_cyc[k][i], exp_ferr[k][i]); end
      end
      checks++; if (ovr_cyc[k].size() !== 0) begin errors++; $display("FAIL rand_ovr[%0d]: got %0d expected 0", k, ovr_cyc[k].size()); end
    end
  endtask

  initial begin
    test_reset();
    test_cpb1_latency();
    test_back_to_back();
    test_glitch();
    test_break();
    test_overrun();
    test_random();
    test_reset_midframe();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
